// File: rtl/i2s_tx_frame_fifo.sv
// i2s_tx_frame_fifo: stereo frame FIFO feeding the i2s transmit path, with priming,
// underrun accounting and fill-level reporting.
module i2s_tx_frame_fifo #(
    parameter int DATA_BIT = 16,
    parameter int DEPTH    = 16,
    parameter int PRIME    = 8
) (
    input  logic                     i_clk_12_288,
    input  logic                     i_reset_n,
    input  logic [DATA_BIT-1:0]      i_wr_l,
    input  logic [DATA_BIT-1:0]      i_wr_r,
    input  logic                     i_wr_valid,
    output logic                     o_wr_ready,
    input  logic                     i_frame_start,
    input  logic                     i_clear_underrun,
    output logic [DATA_BIT-1:0]      o_audio_l,
    output logic [DATA_BIT-1:0]      o_audio_r,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_playing,
    output logic [15:0]              o_underrun_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {FILL, PLAY} state_t;

    state_t            state, state_next;
    logic [DATA_BIT-1:0] mem_l [DEPTH];
    logic [DATA_BIT-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              wr, pop, underrun;

    assign o_wr_ready = o_level != (AW+1)'(DEPTH);
    assign wr         = i_wr_valid && o_wr_ready;
    assign pop        = i_frame_start && state == PLAY && o_level != '0;
    assign underrun   = i_frame_start && state == PLAY && o_level == '0;
    assign o_playing  = state == PLAY;

    always_comb begin
        state_next = state;
        if (state == FILL && o_level >= (AW+1)'(PRIME))
            state_next = PLAY;
        else if (underrun)
            state_next = FILL;
    end

    always_ff @(posedge i_clk_12_288 or negedge i_reset_n)
        if (!i_reset_n)
            state <= FILL;
        else
            state <= state_next;

    // Storage is not reset; only pointers and level define what is valid.
    always_ff @(posedge i_clk_12_288)
        if (wr) begin
            mem_l[wr_ptr] <= i_wr_l;
            mem_r[wr_ptr] <= i_wr_r;
        end

    always_ff @(posedge i_clk_12_288 or negedge i_reset_n)
        if (!i_reset_n) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            o_level          <= '0;
            o_audio_l        <= '0;
            o_audio_r        <= '0;
            o_underrun_count <= '0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            o_level <= o_level + (AW+1)'(wr) - (AW+1)'(pop);
            if (i_frame_start) begin
                o_audio_l <= pop ? mem_l[rd_ptr] : '0;
                o_audio_r <= pop ? mem_r[rd_ptr] : '0;
            end
            if (i_clear_underrun)
                o_underrun_count <= '0;
            else if (underrun && o_underrun_count != 16'hFFFF)
                o_underrun_count <= o_underrun_count + 16'd1;
        end
endmodule

// File: tb/tb_i2s_tx_frame_fifo.sv
// tb_i2s_tx_frame_fifo: scenario tasks plus randomized traffic against a queue-based
// model of the frame buffer.
module tb_i2s_tx_frame_fifo;
    localparam int DEPTH = 16;
    localparam int PRIME = 8;

    logic        clk = 0;
    logic        rst_n = 0;
    logic [15:0] wr_l = 0, wr_r = 0;
    logic        wr_valid = 0, frame_start = 0, clear_underrun = 0;
    logic        wr_ready, playing;
    logic [15:0] audio_l, audio_r, underrun_count;
    logic [4:0]  level;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] q[$];
    logic        m_play;
    logic [15:0] m_l, m_r, m_cnt;
    logic        last_acc;

    i2s_tx_frame_fifo #(.DATA_BIT(16), .DEPTH(DEPTH), .PRIME(PRIME)) dut (
        .i_clk_12_288(clk), .i_reset_n(rst_n),
        .i_wr_l(wr_l), .i_wr_r(wr_r), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
        .i_frame_start(frame_start), .i_clear_underrun(clear_underrun),
        .o_audio_l(audio_l), .o_audio_r(audio_r), .o_level(level),
        .o_playing(playing), .o_underrun_count(underrun_count)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        q.delete();
        m_play = 0;
        m_l = 0;
        m_r = 0;
        m_cnt = 0;
    endtask

    // One clock: drive inputs, advance the model on the edge, settle #1 after it.
    task automatic step(input logic wv, input logic [15:0] l, input logic [15:0] r,
                        input logic fs, input logic clr);
        int  sz;
        logic und;
        logic [31:0] f;
        wr_valid = wv; wr_l = l; wr_r = r; frame_start = fs; clear_underrun = clr;
        @(posedge clk);
        sz = q.size();
        last_acc = wv && sz != DEPTH;
        und = fs && m_play && sz == 0;
        if (fs) begin
            if (m_play && sz > 0) begin
                f = q.pop_front();
                m_l = f[31:16];
                m_r = f[15:0];
            end else begin
                m_l = 0;
                m_r = 0;
            end
        end
        if (last_acc) q.push_back({l, r});
        if (clr) m_cnt = 0;
        else if (und && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        m_play = m_play ? !und : (sz >= PRIME);
        #1;
        wr_valid = 0; frame_start = 0; clear_underrun = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        wr_valid = 0; frame_start = 0; clear_underrun = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        model_clear();
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) step(1, 16'($urandom), 16'($urandom), 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({audio_l, audio_r, level, playing, underrun_count, wr_ready} !== {16'h0, 16'h0, 5'd0, 1'b0, 16'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_state got l=%h r=%h lvl=%0d play=%b cnt=%0d rdy=%b want zeros rdy=1",
                     audio_l, audio_r, level, playing, underrun_count, wr_ready);
        end
    endtask

    task automatic test_prime();
        for (int k = 1; k <= 7; k++) step(1, 16'(k), 16'h8000 | 16'(k), 0, 0);
        for (int i = 0; i < 3; i++) begin step(0, 0, 0, 1, 0); step(0, 0, 0, 0, 0); end
        vectors++;
        if ({playing, audio_l, audio_r, level, underrun_count} !== {1'b0, 16'h0, 16'h0, 5'd7, 16'h0}) begin
            miscompares++;
            $display("FAIL prime_hold got play=%b l=%h r=%h lvl=%0d cnt=%0d want play=0 l=0 r=0 lvl=7 cnt=0",
                     playing, audio_l, audio_r, level, underrun_count);
        end
    endtask

    task automatic test_play();
        step(1, 16'h0008, 16'h8008, 0, 0);
        vectors++;
        if ({playing, level} !== {1'b0, 5'd8}) begin
            miscompares++;
            $display("FAIL play_edge got play=%b lvl=%0d want play=0 lvl=8", playing, level);
        end
        step(0, 0, 0, 0, 0);
        vectors++;
        if (playing !== 1'b1) begin
            miscompares++;
            $display("FAIL play_start got play=%b want 1", playing);
        end
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 0, 1, 0);
            vectors++;
            if ({audio_l, audio_r, level} !== {16'(k), 16'h8000 | 16'(k), 5'(8 - k)}) begin
                miscompares++;
                $display("FAIL play_frame%0d got l=%h r=%h lvl=%0d want l=%h r=%h lvl=%0d",
                         k, audio_l, audio_r, level, 16'(k), 16'h8000 | 16'(k), 8 - k);
            end
            step(0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_full();
        int acc = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 16'($urandom), 16'($urandom), 0, 0);
            if (last_acc) acc++;
        end
        vectors++;
        if ({acc == 16, level, wr_ready} !== {1'b1, 5'd16, 1'b0}) begin
            miscompares++;
            $display("FAIL full got acc=%0d lvl=%0d rdy=%b want acc=16 lvl=16 rdy=0", acc, level, wr_ready);
        end
        step(1, 16'($urandom), 16'($urandom), 1, 0);
        vectors++;
        if ({audio_l, audio_r, level, wr_ready} !== {m_l, m_r, 5'd15, 1'b1}) begin
            miscompares++;
            $display("FAIL full_pop got l=%h r=%h lvl=%0d rdy=%b want l=%h r=%h lvl=15 rdy=1",
                     audio_l, audio_r, level, wr_ready, m_l, m_r);
        end
        step(1, 16'($urandom), 16'($urandom), 0, 0);
        vectors++;
        if ({level, wr_ready} !== {5'd16, 1'b0}) begin
            miscompares++;
            $display("FAIL full_refill got lvl=%0d rdy=%b want lvl=16 rdy=0", level, wr_ready);
        end
    endtask

    task automatic test_underrun();
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 1, 0);
            vectors++;
            if ({audio_l, audio_r, level} !== {m_l, m_r, 5'(15 - i)}) begin
                miscompares++;
                $display("FAIL drain%0d got l=%h r=%h lvl=%0d want l=%h r=%h lvl=%0d",
                         i, audio_l, audio_r, level, m_l, m_r, 15 - i);
            end
        end
        step(0, 0, 0, 1, 0);
        vectors++;
        if ({audio_l, audio_r, underrun_count, playing} !== {16'h0, 16'h0, 16'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL underrun got l=%h r=%h cnt=%0d play=%b want l=0 r=0 cnt=1 play=0",
                     audio_l, audio_r, underrun_count, playing);
        end
        fill_rand(8);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 1, 0);
            vectors++;
            if ({audio_l, audio_r, level, playing} !== {m_l, m_r, 5'(7 - i), 1'b1}) begin
                miscompares++;
                $display("FAIL resume%0d got l=%h r=%h lvl=%0d play=%b want l=%h r=%h lvl=%0d play=1",
                         i, audio_l, audio_r, level, playing, m_l, m_r, 7 - i);
            end
        end
    endtask

    task automatic prime_drain_underrun(input logic clr);
        fill_rand(PRIME);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < PRIME; i++) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, clr);
    endtask

    task automatic test_saturate();
        do_reset();
        force dut.o_underrun_count = 16'hFFFE;
        #2 release dut.o_underrun_count;
        m_cnt = 16'hFFFE;
        prime_drain_underrun(0);
        vectors++;
        if (underrun_count !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL sat_reach got %h want ffff", underrun_count);
        end
        prime_drain_underrun(0);
        vectors++;
        if (underrun_count !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL sat_hold got %h want ffff", underrun_count);
        end
        prime_drain_underrun(1);
        vectors++;
        if ({underrun_count, playing} !== {16'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL clear_wins got cnt=%h play=%b want cnt=0 play=0", underrun_count, playing);
        end
    endtask

    task automatic test_random();
        int wp, fp;
        for (int i = 0; i < 4000; i++) begin
            wp = (i < 2000) ? 30 : 65;
            fp = (i < 2000) ? 45 : 25;
            step($urandom_range(99) < wp, 16'($urandom), 16'($urandom),
                 $urandom_range(99) < fp, $urandom_range(99) < 2);
            vectors++;
            if ({audio_l, audio_r, level, playing, underrun_count, wr_ready} !==
                {m_l, m_r, 5'(q.size()), m_play, m_cnt, q.size() != DEPTH}) begin
                miscompares++;
                $display("FAIL random%0d got l=%h r=%h lvl=%0d play=%b cnt=%0d rdy=%b want l=%h r=%h lvl=%0d play=%b cnt=%0d",
                         i, audio_l, audio_r, level, playing, underrun_count, wr_ready,
                         m_l, m_r, q.size(), m_play, m_cnt);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] fl, fr;
        do_reset();
        fill_rand(8);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin step(0, 0, 0, 1, 0); step(0, 0, 0, 0, 0); end
        vectors++;
        if ({level, playing} !== {5'd5, 1'b1}) begin
            miscompares++;
            $display("FAIL pre_reset got lvl=%0d play=%b want lvl=5 play=1", level, playing);
        end
        #2 rst_n = 0;
        #1;
        vectors++;
        if ({audio_l, audio_r, level, playing, underrun_count, wr_ready} !== {16'h0, 16'h0, 5'd0, 1'b0, 16'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL async_reset got l=%h r=%h lvl=%0d play=%b cnt=%0d rdy=%b want zeros rdy=1",
                     audio_l, audio_r, level, playing, underrun_count, wr_ready);
        end
        @(posedge clk);
        #1 rst_n = 1;
        model_clear();
        fl = 16'($urandom);
        fr = 16'($urandom);
        step(1, fl, fr, 0, 0);
        fill_rand(7);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        vectors++;
        if ({audio_l, audio_r, level} !== {fl, fr, 5'd7}) begin
            miscompares++;
            $display("FAIL post_reset_first got l=%h r=%h lvl=%0d want l=%h r=%h lvl=7",
                     audio_l, audio_r, level, fl, fr);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_prime();
        test_play();
        test_full();
        test_underrun();
        test_saturate();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/i2s_tx_frame_fifo.md
Name: i2s_tx_frame_fifo

Overview:
- Stereo sample buffer that sits directly upstream of the i2s transceiver's transmit path.
- Accepts left/right frames from a producer (tone generator, DSP, host) over a valid/ready handshake, in the same clock domain.
- Presents one held frame on o_audio_l/o_audio_r, advanced once per i2s frame strobe, which is driven from the i2s block's o_audio_valid.
- Adds priming after reset or underrun, underrun accounting and fill-level reporting.

Parameters:
DATA_BIT, 16, width of each channel sample.
DEPTH, 16, FIFO depth in stereo frames; power of two, >= 2.
PRIME, 8, frames that must be buffered before playback starts; 1 <= PRIME <= DEPTH.

Ports:
i_clk_12_288  input  1  system clock; all logic on rising edge.
i_reset_n  input  1  asynchronous active-low reset.
i_wr_l  input  DATA_BIT  left sample of the incoming frame.
i_wr_r  input  DATA_BIT  right sample of the incoming frame.
i_wr_valid  input  1  producer has a frame on i_wr_l/i_wr_r.
o_wr_ready  output  1  FIFO can accept a frame this cycle.
i_frame_start  input  1  one-cycle strobe per i2s frame; connects to i2s o_audio_valid.
i_clear_underrun  input  1  synchronous clear of o_underrun_count.
o_audio_l  output  DATA_BIT  held left sample; connects to i2s i_audio_l.
o_audio_r  output  DATA_BIT  held right sample; connects to i2s i_audio_r.
o_level  output  $clog2(DEPTH)+1  frames currently stored, 0..DEPTH.
o_playing  output  1  high in PLAY state.
o_underrun_count  output  16  saturating count of underrun events.

Behaviour:
- Reset (async, i_reset_n low):
  - outputs: o_audio_l/o_audio_r = 0, o_level = 0, o_playing = 0, o_underrun_count = 0; o_wr_ready = 1, since it is derived from an empty FIFO.
  - internal: pointers = 0, state = FILL.
  - Storage contents need not be reset.
  - Reset mid-operation discards all buffered frames.
- Write side:
  - A write occurs when i_wr_valid && o_wr_ready.
  - o_wr_ready = (o_level != DEPTH); combinational from registered level.
  - Write pointer wraps modulo DEPTH.
  - Frame is visible to reads from the next cycle; there is no same-cycle bypass.
- Read side, evaluated only when i_frame_start = 1:
  - FILL: o_audio_l/r <= 0; no pop; no underrun counted.
  - PLAY, level > 0: o_audio_l/r <= head frame, registered, so valid the cycle after the strobe; pop; read pointer wraps modulo DEPTH.
  - PLAY, level == 0: underrun. o_audio_l/r <= 0; no pop; o_underrun_count += 1, saturating at 16'hFFFF; state <= FILL.
- Outputs are held between strobes.
  - Latency from strobe to new output: 1 clock.
  - The i2s block samples its inputs at the frame finish, many clocks later.
- State machine, 2 states:
  - FILL -> PLAY when o_level >= PRIME, evaluated every cycle on the registered level. The first pop can occur on the first strobe after the transition.
  - PLAY -> FILL on underrun only.
  - o_playing = (state == PLAY).
- Level update:
  - level_next = level + write - pop, where write = accepted write and pop = strobe-driven pop.
  - Simultaneous write and pop leaves the level unchanged.
  - A full FIFO cannot write, so the level never exceeds DEPTH.
  - Write and strobe in the same cycle with level == 0 in PLAY is still an underrun; the written frame remains stored.
- i_clear_underrun:
  - Forces the count to 0 next cycle.
  - If it coincides with an underrun, the clear wins and the result is 0.
- i_frame_start asserted on consecutive cycles: each cycle is treated as an independent strobe. This is not expected in-system.

Test Plan:
- Reset, then 7 writes (PRIME = 8) and 3 strobes -> o_playing = 0, outputs stay 0, o_level = 7, o_underrun_count = 0.
- Write an 8th frame, then strobes -> o_playing = 1 the cycle after level reaches 8. Frames L=16'h0001/R=16'h8001 .. L=16'h0008/R=16'h8008 appear in order, each one cycle after its strobe; o_level decrements 8 -> 0.
- Hold i_wr_valid high with no strobes -> exactly 16 frames accepted, o_wr_ready = 0 at o_level = 16. Then one strobe with valid still high -> pop and a write in the cycle after, level back to 16.
- Drain to empty in PLAY, then one strobe -> outputs 0, o_underrun_count = 1, o_playing = 0. Refill 8 frames -> playback resumes with the next frame, none lost or duplicated.
- Force count to 16'hFFFF via repeated underruns (or a forced bench value), then another underrun -> stays 16'hFFFF. i_clear_underrun together with an underrun -> 0.
- Assert i_reset_n low mid-playback with level 5 -> all outputs reset immediately (async), o_level = 0. First write after release is the first frame read after re-priming.
